// File: rtl/ncl_test_fn_if.sv
// Dual-rail bundle for the ncl_test_fn block: four rail-pair inputs,
// one rail-pair result, plus acknowledge and sticky error.
interface ncl_test_fn_if;
  logic a_t_unused_guard;
  logic A_t, A_f;
  logic B_t, B_f;
  logic C_t, C_f;
  logic D_t, D_f;
  logic Q_t, Q_f;
  logic ko;
  logic err;

  // Producer/consumer side: drives the operand rails, observes result and handshake.
  modport master (
    output A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f,
    input  Q_t, Q_f, ko, err
  );

  // Function block side.
  modport slave (
    input  A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f,
    output Q_t, Q_f, ko, err
  );
endinterface

// File: rtl/ncl_test_fn.sv
// Synchronous dual-rail (NCL-style) evaluator of Q = A | (B ^ (C & D)).
// Inputs are sampled, checked for complete DATA/NULL wavefronts, and Q/ko move only on complete sets.
module ncl_test_fn (
  input  logic           clk,
  input  logic           rst_n,
  ncl_test_fn_if.slave   bus
);

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  // Rail order, MSB first: {A_t, A_f, B_t, B_f, C_t, C_f, D_t, D_f}.
  logic [7:0] in_r;

  logic [3:0] pair_null;
  logic [3:0] pair_data;
  logic [3:0] pair_illegal;
  logic [3:0] rail_t;
  logic       all_data;
  logic       all_null;
  logic       any_illegal;
  logic       fn_q;

  state_t state_q, state_d;
  logic   q_t_q, q_f_q, ko_q, err_q;
  logic   q_t_d, q_f_d, ko_d, err_d;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_r <= '0;
    end else begin
      in_r <= {bus.A_t, bus.A_f, bus.B_t, bus.B_f,
               bus.C_t, bus.C_f, bus.D_t, bus.D_f};
    end
  end

  // Pair index 3 is A (the MSB of the function index), index 0 is D.
  always_comb begin
    pair_null    = '0;
    pair_data    = '0;
    pair_illegal = '0;
    rail_t       = '0;
    for (int i = 0; i < 4; i++) begin
      pair_null[i]    = ~in_r[2*i+1] & ~in_r[2*i];
      pair_data[i]    =  in_r[2*i+1] ^  in_r[2*i];
      pair_illegal[i] =  in_r[2*i+1] &  in_r[2*i];
      rail_t[i]       =  in_r[2*i+1];
    end
  end

  assign all_data    = &pair_data;
  assign all_null    = &pair_null;
  assign any_illegal = |pair_illegal;
  // Only meaningful when all_data holds; the true rail is then the logical value.
  assign fn_q        = rail_t[3] | (rail_t[2] ^ (rail_t[1] & rail_t[0]));

  // State and output registers: reset aborts any wavefront and returns Q to NULL at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_DATA;
      q_t_q   <= 1'b0;
      q_f_q   <= 1'b0;
      ko_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_t_q   <= q_t_d;
      q_f_q   <= q_f_d;
      ko_q    <= ko_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every combinational output is given a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_DATA: if (all_data) state_d = WAIT_NULL;
      WAIT_NULL: if (all_null) state_d = WAIT_DATA;
      default:   state_d = WAIT_DATA;
    endcase
  end

  // Partial or illegal wavefronts fall through to the hold defaults.
  always_comb begin
    q_t_d = q_t_q;
    q_f_d = q_f_q;
    ko_d  = ko_q;
    err_d = err_q | any_illegal;
    unique case (state_q)
      WAIT_DATA: begin
        if (all_data) begin
          q_t_d = fn_q;
          q_f_d = ~fn_q;
          ko_d  = 1'b0;
        end
      end
      WAIT_NULL: begin
        if (all_null) begin
          q_t_d = 1'b0;
          q_f_d = 1'b0;
          ko_d  = 1'b1;
        end
      end
      default: begin
        q_t_d = 1'b0;
        q_f_d = 1'b0;
        ko_d  = 1'b1;
      end
    endcase
  end

  assign bus.Q_t = q_t_q;
  assign bus.Q_f = q_f_q;
  assign bus.ko  = ko_q;
  assign bus.err = err_q;

endmodule

// File: tb/tb_ncl_test_fn.sv
// Scoreboard bench for ncl_test_fn: stimulus pushes expected output tuples,
// a negedge monitor pops and compares whenever {Q_t,Q_f,ko,err} changes.
module tb_ncl_test_fn;

  logic clk = 1'b0;
  logic rst_n;

  ncl_test_fn_if bus ();

  ncl_test_fn dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Q for function index {A,B,C,D}: indices 3..6 and 8..15 are 1.
  localparam logic [15:0] Q_TBL = 16'hFF78;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb_q[$];   // expected {Q_t, Q_f, ko, err}
  logic [3:0] exp_cur;   // model's current output tuple
  logic [3:0] mon_prev;
  logic       mon_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.Q_t, bus.Q_f, bus.ko, bus.err};
  endfunction

  task automatic expect_out(input logic [3:0] nv);
    if (nv != exp_cur) sb_q.push_back(nv);
    exp_cur = nv;
  endtask

  task automatic drive(input logic [7:0] r);
    {bus.A_t, bus.A_f, bus.B_t, bus.B_f, bus.C_t, bus.C_f, bus.D_t, bus.D_f} = r;
  endtask

  function automatic logic [7:0] data_rails(input logic [3:0] idx);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = idx[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic wait_ko(input logic v);
    int n = 0;
    while (bus.ko !== v && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ko_wait", {7'd0, bus.ko}, {7'd0, v});
  endtask

  // Monitor: every observed output change must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && outs() !== mon_prev) begin
        if (sb_q.size() == 0) check("unexpected_change", {4'd0, outs()}, {4'd0, mon_prev});
        else                  check("sb", {4'd0, outs()}, {4'd0, sb_q.pop_front()});
        mon_prev = outs();
      end
    end
  end

  initial begin
    logic [3:0] q_bit;
    logic [7:0] hold_rails;

    // Reset with random inputs: outputs must be the reset values asynchronously.
    rst_n = 1'b1;
    drive(8'($urandom));
    #2 rst_n = 1'b0;
    #1 check("reset_async", {4'd0, outs()}, 8'b0010);
    exp_cur = 4'b0010;
    repeat (2) @(negedge clk);
    drive(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    mon_prev = 4'b0010;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset", {4'd0, outs()}, 8'b0010);

    // Minterm sweep: NULL then DATA for every index.
    for (int i = 0; i < 16; i++) begin
      drive(8'h00);
      expect_out(4'b0010);
      wait_ko(1'b1);
      q_bit = {3'd0, Q_TBL[i]};
      drive(data_rails(4'(i)));
      expect_out({q_bit[0], ~q_bit[0], 2'b00});
      wait_ko(1'b0);
      repeat (2) @(negedge clk);
    end

    // Hysteresis: A,B,C DATA with D NULL must not move anything.
    drive(8'h00);
    expect_out(4'b0010);
    wait_ko(1'b1);
    drive(8'b01_10_10_00);           // A=0, B=1, C=1, D=NULL
    repeat (5) @(negedge clk);
    check("partial_data_hold", {4'd0, outs()}, 8'b0010);
    drive(8'b01_10_10_10);           // index 0111 -> Q=0
    expect_out(4'b0100);
    @(posedge clk);
    @(posedge clk);
    #1 check("complete_latency", {4'd0, outs()}, 8'b0100);

    // A second complete DATA set without NULL is ignored.
    @(negedge clk);
    drive(data_rails(4'b1000));
    repeat (4) @(negedge clk);
    check("data_without_null", {4'd0, outs()}, 8'b0100);

    // Partial return to NULL holds Q; full NULL releases it in 2 edges.
    drive(8'b00_01_01_01);
    repeat (5) @(negedge clk);
    check("partial_null_hold", {4'd0, outs()}, 8'b0100);
    drive(8'h00);
    expect_out(4'b0010);
    @(posedge clk);
    @(posedge clk);
    #1 check("null_latency", {4'd0, outs()}, 8'b0010);

    // Illegal code on C: err after 2 edges, Q unchanged, err sticky.
    @(negedge clk);
    hold_rails = data_rails(4'b1000);
    drive(hold_rails);
    expect_out(4'b1000);
    wait_ko(1'b0);
    @(negedge clk);
    drive({hold_rails[7:4], 2'b11, hold_rails[1:0]});
    expect_out(4'b1001);
    @(posedge clk);
    #1 check("err_not_early", {7'd0, bus.err}, 8'd0);
    @(posedge clk);
    #1 check("err_latency", {4'd0, outs()}, 8'b1001);
    @(negedge clk);
    drive(hold_rails);
    repeat (4) @(negedge clk);
    check("err_sticky", {4'd0, outs()}, 8'b1001);
    drive(8'h00);
    expect_out(4'b0011);
    wait_ko(1'b1);

    // Reset in WAIT_NULL with Q=10: immediate return to NULL, then fresh evaluation.
    drive(data_rails(4'b0101));
    expect_out(4'b1001);
    wait_ko(1'b0);
    @(negedge clk);
    expect_out(4'b0010);
    rst_n = 1'b0;
    #1 check("reset_mid", {4'd0, outs()}, 8'b0010);
    drive(8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(data_rails(4'b0001));      // index 1 -> Q=0
    expect_out(4'b0100);
    wait_ko(1'b0);
    check("fresh_after_reset", {4'd0, outs()}, 8'b0100);

    repeat (3) @(negedge clk);
    check("sb_drained", 8'(sb_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ncl_test_fn.md
# ncl_test_fn

Clocked four-input dual-rail (NULL Convention Logic style) function block computing Q = A | (B ^ (C & D)). Every logical signal travels on a true/false rail pair, and data arrives in alternating DATA and NULL wavefronts. It sits between dual-rail producer and consumer stages and emits an acknowledge (`ko`) and a sticky protocol-error flag. It is implemented synchronously: inputs are sampled, completeness is checked, and the output changes only on complete wavefronts.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A_t`, `A_f`  in  1 each  dual-rail input A: 00 = NULL, 01 = DATA0, 10 = DATA1, 11 = illegal.
- `B_t`, `B_f`  in  1 each  dual-rail input B, same encoding.
- `C_t`, `C_f`  in  1 each  dual-rail input C, same encoding.
- `D_t`, `D_f`  in  1 each  dual-rail input D, same encoding.
- `Q_t`, `Q_f`  out  1 each  dual-rail result Q, registered; never 11.
- `ko`  out  1  registered completion/acknowledge: 1 = ready for DATA, 0 = ready for NULL.
- `err`  out  1  sticky flag, set on any illegal (11) input pair.

## Operation
- Input register `in_r` (8 bits) samples all rail pairs every rising edge.
- Per pair, from `in_r`: `isnull` = 00, `isdata` = 01 or 10, `illegal` = 11.
- Whole-wavefront conditions:
  - `all_data` = all four pairs are DATA.
  - `all_null` = all four pairs are NULL.
  - Any other combination, including any illegal pair, is incomplete.
- Function, with index {A,B,C,D} and A as the MSB: Q = A | (B ^ (C & D)).
  - Index 0 → 0; 1 → 0; 2 → 0; 3 → 1; 4 → 1.
  - Indices 8–15 → 1.
- State machine, 2 states.
  - WAIT_DATA:
    - On `all_data`: drive Q rails to the function value (Q=1 → `Q_t`=1, `Q_f`=0; Q=0 → `Q_t`=0, `Q_f`=1), set `ko`=0, go to WAIT_NULL.
    - Otherwise hold.
  - WAIT_NULL:
    - On `all_null`: set `Q_t`=`Q_f`=0, set `ko`=1, go to WAIT_DATA.
    - Otherwise hold. A new complete DATA set arriving without an intervening NULL is ignored; Q does not change.
- Hysteresis: a partial wavefront (some pairs DATA, some NULL) never changes Q or `ko`.
- `err`: set at the edge after `in_r` holds any 11 pair; cleared only by reset. An illegal pair counts as incomplete.
- Reset (async, `rst_n`=0):
  - Clears `in_r`.
  - `Q_t`=0, `Q_f`=0, `ko`=1, `err`=0.
  - State returns to WAIT_DATA.
  - Release is synchronous to the next rising edge. Assertion mid-wavefront aborts the wavefront; Q returns to NULL immediately.

## Timing
- Latency: 2 rising edges from inputs becoming stable and complete to `Q_t`/`Q_f`/`ko` updating (input sample, then output register).
- Outputs are glitch-free registered values and change at most once per wavefront.
- Producers hold each wavefront until `ko` toggles. Stability for at least 3 cycles is guaranteed correct.
- `err` latency: 2 edges after the illegal code appears on the pins.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → `Q_t`=0, `Q_f`=0, `ko`=1, `err`=0 asynchronously.
- Minterm sweep: for each index 0–15, drive NULL (wait for `ko`=1), then DATA (wait for `ko`=0).
  - Index 0011 → `Q_t`=1, `Q_f`=0.
  - Index 0100 → `Q_t`=1, `Q_f`=0.
  - Index 0001 and 0010 → `Q_t`=0, `Q_f`=1.
  - Index 1xxx → `Q_t`=1, `Q_f`=0.
- Hysteresis: after NULL, drive A,B,C DATA with D still NULL for 5 cycles → Q stays 00, `ko` stays 1. Then complete D → Q valid 2 edges later.
- Return to NULL partially: from valid Q, release only A to NULL → Q holds. Release all to NULL → Q=00, `ko`=1 after 2 edges.
- Illegal code: drive `C_t`=`C_f`=1 → `err`=1 after 2 edges, Q unchanged. Restore legal inputs → `err` stays 1 until reset.
- Reset mid-operation: assert `rst_n` while in WAIT_NULL with Q=10 → Q=00, `ko`=1 immediately. After release, a fresh DATA wavefront evaluates normally.
